// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with parallel load, logical shifts left/right,
// rotates left/right, synchronous clear and a saturating shift counter.
//
// Ports
//   clk      : single clock, all state changes on its rising edge
//   rst_n    : asynchronous active-low reset (q=0, cnt=0)
//   en       : operation enable; when low, q and cnt hold
//   mode     : operation select
//                000 hold, 001 load, 010 shl, 011 shr,
//                100 rotl, 101 rotr, 110 clear, 111 hold
//   d        : parallel load data
//   si_l     : serial input entering bit 0 on a left shift
//   si_r     : serial input entering bit WIDTH-1 on a right shift
//   q        : register contents
//   q_bar    : bitwise inverse of q
//   cnt      : shifts since the last load/clear, saturating at WIDTH
//   drained  : high when cnt == WIDTH
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       si_l,
  input  logic                       si_r,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_bar,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    w_cnt_next;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_cnt_full;

  // Counter saturates at WIDTH; the shift itself still happens at saturation.
  assign w_cnt_full = (r_cnt == CW'(WIDTH));
  assign w_cnt_inc  = w_cnt_full ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          w_q_next   = d;
          w_cnt_next = '0;
        end
        MODE_SHL: begin
          w_q_next   = {r_q[WIDTH-2:0], si_l};
          w_cnt_next = w_cnt_inc;
        end
        MODE_SHR: begin
          w_q_next   = {si_r, r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_ROTL: w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROTR: w_q_next = {r_q[0], r_q[WIDTH-1:1]};
        MODE_CLEAR: begin
          w_q_next   = '0;
          w_cnt_next = '0;
        end
        MODE_HOLD, MODE_RSVD: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
        default: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  // All outputs derive only from the two state registers.
  assign q       = r_q;
  assign q_bar   = ~r_q;
  assign cnt     = r_cnt;
  assign drained = w_cnt_full;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             si_l;
  logic             si_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [CW-1:0]    cnt;
  logic             drained;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .si_l    (si_l),
    .si_r    (si_r),
    .q       (q),
    .q_bar   (q_bar),
    .cnt     (cnt),
    .drained (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       drn;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       drn;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic [2:0] m, logic [7:0] dd, logic l, logic r,
                              logic [7:0] eq, logic [3:0] ec, logic edr, string nm);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.sil = l; v.sir = r;
    v.q = eq; v.cnt = ec; v.drn = edr; v.name = nm;
    return v;
  endfunction

  task automatic check_now(exp_t e);
    checks++;
    if (q !== e.q) begin
      errors++;
      $display("FAIL %s q: got %h want %h", e.name, q, e.q);
    end
    checks++;
    if (q_bar !== ~e.q) begin
      errors++;
      $display("FAIL %s q_bar: got %h want %h", e.name, q_bar, ~e.q);
    end
    checks++;
    if (cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s cnt: got %0d want %0d", e.name, cnt, e.cnt);
    end
    checks++;
    if (drained !== e.drn) begin
      errors++;
      $display("FAIL %s drained: got %b want %b", e.name, drained, e.drn);
    end
    $display("txn %-12s q=%h q_bar=%h cnt=%0d drained=%b", e.name, q, q_bar, cnt, drained);
  endtask

  // Drive one operation at the falling edge, expect the result one rising edge later.
  task automatic apply(vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    en = v.en; mode = v.mode; d = v.d; si_l = v.sil; si_r = v.sir;
    e.q = v.q; e.cnt = v.cnt; e.drn = v.drn; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty want entry", v.name);
    end else begin
      got = sb.pop_front();
      check_now(got);
    end
  endtask

  task automatic expect_now(logic [7:0] eq, logic [3:0] ec, logic edr, string nm);
    exp_t e;
    e.q = eq; e.cnt = ec; e.drn = edr; e.name = nm;
    check_now(e);
  endtask

  initial begin
    // mode codes: 0 hold 1 load 2 shl 3 shr 4 rotl 5 rotr 6 clear 7 rsvd
    tbl.push_back(mk(1, 3'd1, 8'hA5, 0, 0, 8'hA5, 0, 0, "load_A5"));
    tbl.push_back(mk(1, 3'd1, 8'h81, 0, 0, 8'h81, 0, 0, "load_81"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h02, 1, 0, "shl1"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h04, 2, 0, "shl2"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h08, 3, 0, "shl3"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h10, 4, 0, "shl4"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h20, 5, 0, "shl5"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h40, 6, 0, "shl6"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h80, 7, 0, "shl7"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h00, 8, 1, "shl8"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 1, 0, 8'h01, 8, 1, "shl9_sat"));
    tbl.push_back(mk(1, 3'd1, 8'h81, 0, 0, 8'h81, 0, 0, "load_81b"));
    tbl.push_back(mk(1, 3'd5, 8'h00, 0, 0, 8'hC0, 0, 0, "rotr"));
    tbl.push_back(mk(1, 3'd4, 8'h00, 0, 0, 8'h81, 0, 0, "rotl"));
    tbl.push_back(mk(1, 3'd1, 8'h0F, 0, 0, 8'h0F, 0, 0, "load_0F"));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 1, 8'h87, 1, 0, "shr1"));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 1, 8'hC3, 2, 0, "shr2"));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 1, 8'hE1, 3, 0, "shr3"));
    tbl.push_back(mk(0, 3'd3, 8'h00, 0, 1, 8'hE1, 3, 0, "en0_shr_a"));
    tbl.push_back(mk(0, 3'd3, 8'h00, 0, 1, 8'hE1, 3, 0, "en0_shr_b"));
    tbl.push_back(mk(1, 3'd7, 8'hFF, 1, 1, 8'hE1, 3, 0, "rsvd_111"));
    tbl.push_back(mk(1, 3'd0, 8'hFF, 1, 1, 8'hE1, 3, 0, "hold_000"));
    tbl.push_back(mk(1, 3'd2, 8'h00, 1, 0, 8'hC3, 4, 0, "shl_si1"));
    tbl.push_back(mk(1, 3'd6, 8'hFF, 1, 1, 8'h00, 0, 0, "clear"));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 1, 8'h80, 1, 0, "shr_after_clr"));
    tbl.push_back(mk(0, 3'd1, 8'hFF, 0, 0, 8'h80, 1, 0, "en0_load"));

    en = 0; mode = 3'd0; d = '0; si_l = 0; si_r = 0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(8'h00, 0, 0, "reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset pulsed between edges in the middle of a shift run.
    apply(mk(1, 3'd1, 8'hFF, 0, 0, 8'hFF, 0, 0, "load_FF"));
    apply(mk(1, 3'd2, 8'h00, 0, 0, 8'hFE, 1, 0, "mid_shl1"));
    apply(mk(1, 3'd2, 8'h00, 0, 0, 8'hFC, 2, 0, "mid_shl2"));
    apply(mk(1, 3'd2, 8'h00, 0, 0, 8'hF8, 3, 0, "mid_shl3"));
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(8'h00, 0, 0, "mid_reset");
    // Edges while reset is held must not load anything.
    @(negedge clk);
    en = 1; mode = 3'd1; d = 8'h3C;
    @(posedge clk);
    #1;
    expect_now(8'h00, 0, 0, "rst_hold_edge");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 3'd6, 8'h3C, 0, 0, 8'h00, 0, 0, "clear_post"));
    apply(mk(1, 3'd1, 8'h5A, 0, 0, 8'h5A, 0, 0, "load_5A"));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
